// File: rtl/ofdm_frame_sequencer_pkg.sv
// Shared types and defaults for the OFDM frame sequencer.
package ofdm_frame_sequencer_pkg;

    localparam int OFDM_SIZE_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/ofdm_frame_sequencer_sym_counter.sv
// Sample/symbol position counter; advances exactly when the symbol builder consumes a sample.
module ofdm_frame_sequencer_sym_counter
    import ofdm_frame_sequencer_pkg::*;
#(
    parameter int OFDM_SIZE = OFDM_SIZE_DEF,
    parameter int N_PRE     = 2,
    parameter int N_SYM     = 18,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] samp_cnt,
    output logic [7:0]       sym_idx,
    output logic             samp_last,
    output logic             sym_pre_last,
    output logic             sym_last
);

    assign samp_last    = (samp_cnt == CNT_W'(OFDM_SIZE - 1));
    assign sym_pre_last = (sym_idx == 8'(N_PRE - 1));
    assign sym_last     = (sym_idx == 8'(N_SYM - 1));

    // Symbol index wraps to 0 after the last data symbol so a continuous frame restarts cleanly.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            samp_cnt <= '0;
            sym_idx  <= '0;
        end else if (clr) begin
            samp_cnt <= '0;
            sym_idx  <= '0;
        end else if (inc) begin
            if (samp_last) begin
                samp_cnt <= '0;
                sym_idx  <= sym_last ? 8'd0 : sym_idx + 8'd1;
            end else begin
                samp_cnt <= samp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// Frame-level controller gating the OFDM symbol builder through preamble, data and gap phases.
//  state   | meaning
//  ST_IDLE | waiting for start
//  ST_PRE  | builder enabled, preamble source selected
//  ST_DATA | builder enabled, data source selected
//  ST_GAP  | builder disabled, fixed idle clocks before next frame or IDLE
module ofdm_frame_sequencer
    import ofdm_frame_sequencer_pkg::*;
#(
    parameter int OFDM_SIZE  = OFDM_SIZE_DEF,
    parameter int N_PRE      = 2,
    parameter int N_DATA     = 16,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             ready_in,
    output logic             ctrl_en,
    output logic             sel_pre,
    output logic [CNT_W-1:0] samp_cnt,
    output logic [7:0]       sym_idx,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state, state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic             adv;
    logic             samp_last, sym_pre_last, sym_last;
    logic             frame_done, sof_nxt;

    assign adv = ctrl_en && ready_in;

    ofdm_frame_sequencer_sym_counter #(
        .OFDM_SIZE (OFDM_SIZE),
        .N_PRE     (N_PRE),
        .N_SYM     (N_PRE + N_DATA),
        .CNT_W     (CNT_W)
    ) u_sym_counter (
        .clk          (clk),
        .res_n        (res_n),
        .inc          (adv),
        .clr          (abort),
        .samp_cnt     (samp_cnt),
        .sym_idx      (sym_idx),
        .samp_last    (samp_last),
        .sym_pre_last (sym_pre_last),
        .sym_last     (sym_last)
    );

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        sof_nxt    = adv && (samp_cnt == '0) && (sym_idx == '0) && !abort;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_PRE;
            ST_PRE:  if (adv && samp_last && sym_pre_last) state_nxt = ST_DATA;
            ST_DATA: begin
                if (adv && samp_last && sym_last) begin
                    state_nxt  = ST_GAP;
                    frame_done = 1'b1;
                end
            end
            ST_GAP:  if (gap_cnt == '0) state_nxt = cont ? ST_PRE : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything, including a frame that would complete this clock.
        if (abort) begin
            state_nxt  = ST_IDLE;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= ST_IDLE;
            ctrl_en   <= 1'b0;
            sel_pre   <= 1'b0;
            busy      <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            ctrl_en <= (state_nxt == ST_PRE) || (state_nxt == ST_DATA);
            sel_pre <= (state_nxt == ST_PRE);
            busy    <= (state_nxt != ST_IDLE);
            sof     <= sof_nxt;
            eof     <= frame_done;
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (state != ST_GAP) gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

endmodule
